// File: rtl/multiplexer_n_to_1_stream_pkg.sv
// Shared constants for the N:1 stream multiplexer: mode encodings and default sizes.
package multiplexer_pkg;

  localparam logic MODE_FIXED       = 1'b0;
  localparam logic MODE_ROUND_ROBIN = 1'b1;

  localparam int DEFAULT_CHANNEL_COUNT = 4;
  localparam int DEFAULT_DATA_WIDTH    = 8;
  localparam int DEFAULT_COUNT_WIDTH   = 16;

endpackage

// File: rtl/multiplexer_n_to_1_stream_if.sv
// Bundle of producer-side and consumer-side stream signals around the N:1 multiplexer.
interface multiplexer_n_to_1_stream_if
  import multiplexer_pkg::*;
#(
  parameter int CHANNEL_COUNT   = DEFAULT_CHANNEL_COUNT,
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int SELECTION_WIDTH = $clog2(CHANNEL_COUNT),
  parameter int COUNT_WIDTH     = DEFAULT_COUNT_WIDTH
) ();

  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] input_signal;
  logic [CHANNEL_COUNT-1:0]            input_valid;
  logic [CHANNEL_COUNT-1:0]            input_ready;
  logic [SELECTION_WIDTH-1:0]          selection;
  logic                                mode;
  logic [DATA_WIDTH-1:0]               output_signal;
  logic                                output_valid;
  logic                                output_ready;
  logic [SELECTION_WIDTH-1:0]          output_channel;
  logic [COUNT_WIDTH-1:0]              transfer_count;

  modport master (
    output input_signal, input_valid, selection, mode, output_ready,
    input  input_ready, output_signal, output_valid, output_channel, transfer_count
  );

  modport slave (
    input  input_signal, input_valid, selection, mode, output_ready,
    output input_ready, output_signal, output_valid, output_channel, transfer_count
  );

endinterface

// File: rtl/multiplexer_n_to_1_stream_round_robin_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping, last_grant itself last.
module round_robin_arbiter #(
  parameter  int CHANNEL_COUNT   = 4,
  localparam int SELECTION_WIDTH = $clog2(CHANNEL_COUNT)
) (
  input  logic [CHANNEL_COUNT-1:0]   request,
  input  logic [SELECTION_WIDTH-1:0] last_grant,
  output logic [SELECTION_WIDTH-1:0] grant,
  output logic                       grant_valid
);

  // Scan from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int offset = CHANNEL_COUNT; offset >= 1; offset--) begin
      int idx;
      idx = (int'(last_grant) + offset) % CHANNEL_COUNT;
      if (request[idx]) begin
        grant       = SELECTION_WIDTH'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multiplexer_n_to_1_stream.sv
// N:1 stream multiplexer with fixed or round-robin selection and a registered valid/ready output stage.
module multiplexer_n_to_1_stream
  import multiplexer_pkg::*;
#(
  parameter int CHANNEL_COUNT   = DEFAULT_CHANNEL_COUNT,
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int SELECTION_WIDTH = $clog2(CHANNEL_COUNT),
  parameter int COUNT_WIDTH     = DEFAULT_COUNT_WIDTH
) (
  input logic                          clock,
  input logic                          reset_n,
  multiplexer_n_to_1_stream_if.slave   bus
);

  logic [SELECTION_WIDTH-1:0] last_grant;
  logic [SELECTION_WIDTH-1:0] rr_index;
  logic                       rr_valid;
  logic [SELECTION_WIDTH-1:0] fixed_index;
  logic                       fixed_valid;
  logic [SELECTION_WIDTH-1:0] grant_index;
  logic                       grant_valid;
  logic                       load_enable;
  logic                       transfer;
  logic [DATA_WIDTH-1:0]      grant_data;
  logic [CHANNEL_COUNT-1:0]   ready_vec;

  round_robin_arbiter #(.CHANNEL_COUNT(CHANNEL_COUNT)) u_arbiter (
    .request     (bus.input_valid),
    .last_grant  (last_grant),
    .grant       (rr_index),
    .grant_valid (rr_valid)
  );

  // Out-of-range selections simply never match a channel index.
  always_comb begin
    fixed_index = bus.selection;
    fixed_valid = 1'b0;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      if (bus.selection == SELECTION_WIDTH'(i) && bus.input_valid[i]) fixed_valid = 1'b1;
    end
  end

  always_comb begin
    load_enable = !bus.output_valid || bus.output_ready;
    if (bus.mode == MODE_ROUND_ROBIN) begin
      grant_index = rr_index;
      grant_valid = rr_valid;
    end else begin
      grant_index = fixed_index;
      grant_valid = fixed_valid;
    end
    // Gating with reset_n keeps producers from seeing a handshake the held-in-reset stage will drop.
    transfer   = grant_valid && load_enable && reset_n;
    ready_vec  = '0;
    grant_data = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      if (grant_index == SELECTION_WIDTH'(i)) begin
        ready_vec[i] = transfer;
        grant_data   = bus.input_signal[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.input_ready = ready_vec;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.output_valid   <= 1'b0;
      bus.output_signal  <= '0;
      bus.output_channel <= '0;
      bus.transfer_count <= '0;
      last_grant         <= SELECTION_WIDTH'(CHANNEL_COUNT - 1);
    end else if (load_enable) begin
      if (transfer) begin
        bus.output_valid   <= 1'b1;
        bus.output_signal  <= grant_data;
        bus.output_channel <= grant_index;
        bus.transfer_count <= bus.transfer_count + 1'b1;
        last_grant         <= grant_index;
      end else begin
        bus.output_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multiplexer_n_to_1_stream.sv
// Directed bench: vector table for single-cycle behaviour plus hand sequences for multi-cycle corners.
module tb_multiplexer_n_to_1_stream;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  multiplexer_n_to_1_stream_if bus ();
  multiplexer_n_to_1_stream_if #(.CHANNEL_COUNT(3), .COUNT_WIDTH(4)) bus3 ();

  multiplexer_n_to_1_stream dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  multiplexer_n_to_1_stream #(.CHANNEL_COUNT(3), .COUNT_WIDTH(4)) dut3 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic        ordy;
    logic [3:0]  exp_ready;
    logic        exp_ov;
    logic [1:0]  exp_ch;
    logic [7:0]  exp_data;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;

    bus.input_signal  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.input_valid   = 4'b0000;
    bus.selection     = 2'd0;
    bus.mode          = 1'b0;
    bus.output_ready  = 1'b1;
    bus3.input_signal = {8'hB2, 8'hB1, 8'hB0};
    bus3.input_valid  = 3'b000;
    bus3.selection    = 2'd0;
    bus3.mode         = 1'b0;
    bus3.output_ready = 1'b1;

    //          mode sel  valid    ordy rdy      ov    ch    data   count
    vecs[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 16'd1};
    vecs[1]  = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA2, 16'd1};
    vecs[2]  = '{1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 16'd2};
    vecs[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 16'd3};
    vecs[4]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3, 16'd4};
    vecs[5]  = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'hA3, 16'd4};
    vecs[6]  = '{1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 16'd5};
    vecs[7]  = '{1'b0, 2'd1, 4'b0100, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA2, 16'd5};
    vecs[8]  = '{1'b1, 2'd1, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 16'd6};
    vecs[9]  = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA2, 16'd6};
    vecs[10] = '{1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 16'd7};

    // Reset and idle
    do_reset();
    chk("idle_valid", 32'(bus.output_valid), 32'd0);
    chk("idle_data", 32'(bus.output_signal), 32'd0);
    chk("idle_channel", 32'(bus.output_channel), 32'd0);
    chk("idle_count", 32'(bus.transfer_count), 32'd0);
    chk("idle_ready", 32'(bus.input_ready), 32'd0);

    // Vector table
    for (int v = 0; v < 11; v++) begin
      bus.mode         = vecs[v].mode;
      bus.selection    = vecs[v].sel;
      bus.input_valid  = vecs[v].valid;
      bus.output_ready = vecs[v].ordy;
      #1;
      chk($sformatf("vec%0d_ready", v), 32'(bus.input_ready), 32'(vecs[v].exp_ready));
      tick();
      chk($sformatf("vec%0d_valid", v), 32'(bus.output_valid), 32'(vecs[v].exp_ov));
      chk($sformatf("vec%0d_channel", v), 32'(bus.output_channel), 32'(vecs[v].exp_ch));
      chk($sformatf("vec%0d_data", v), 32'(bus.output_signal), 32'(vecs[v].exp_data));
      chk($sformatf("vec%0d_count", v), 32'(bus.transfer_count), 32'(vecs[v].exp_count));
    end

    // Fixed mode, ten consecutive transfers
    bus.input_valid = 4'b0000;
    do_reset();
    bus.mode = 1'b0; bus.selection = 2'd2; bus.input_valid = 4'b1111; bus.output_ready = 1'b1;
    #1;
    chk("fixed_ready", 32'(bus.input_ready), 32'b0100);
    tick();
    chk("fixed_data", 32'(bus.output_signal), 32'hA2);
    chk("fixed_channel", 32'(bus.output_channel), 32'd2);
    repeat (9) tick();
    chk("fixed_count10", 32'(bus.transfer_count), 32'd10);

    // Round-robin fairness, then channel 1 drops out
    bus.input_valid = 4'b0000;
    do_reset();
    bus.mode = 1'b1; bus.input_valid = 4'b1111;
    begin
      int exp_seq [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0};
      for (int k = 0; k < 12; k++) begin
        if (k == 6) bus.input_valid = 4'b1101;
        tick();
        chk($sformatf("rr_seq%0d_channel", k), 32'(bus.output_channel), 32'(exp_seq[k]));
        chk($sformatf("rr_seq%0d_data", k), 32'(bus.output_signal), 32'hA0 + 32'(exp_seq[k]));
      end
    end

    // Backpressure: word from channel 0 held for five cycles
    bus.input_valid  = 4'b1111;
    bus.output_ready = 1'b0;
    #1;
    chk("bp_ready_pre", 32'(bus.input_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp%0d_valid", k), 32'(bus.output_valid), 32'd1);
      chk($sformatf("bp%0d_data", k), 32'(bus.output_signal), 32'hA0);
      chk($sformatf("bp%0d_channel", k), 32'(bus.output_channel), 32'd0);
      chk($sformatf("bp%0d_ready", k), 32'(bus.input_ready), 32'd0);
    end
    bus.output_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.input_ready), 32'b0010);
    tick();
    chk("bp_next_valid", 32'(bus.output_valid), 32'd1);
    chk("bp_next_channel", 32'(bus.output_channel), 32'd1);
    chk("bp_next_data", 32'(bus.output_signal), 32'hA1);
    tick();
    chk("bp_nobubble_valid", 32'(bus.output_valid), 32'd1);
    chk("bp_nobubble_channel", 32'(bus.output_channel), 32'd2);

    // Asynchronous reset between edges while a word is held
    #2 reset_n = 1'b0;
    #1;
    chk("areset_valid", 32'(bus.output_valid), 32'd0);
    chk("areset_data", 32'(bus.output_signal), 32'd0);
    chk("areset_channel", 32'(bus.output_channel), 32'd0);
    chk("areset_count", 32'(bus.transfer_count), 32'd0);
    chk("areset_ready", 32'(bus.input_ready), 32'd0);
    @(posedge clock);
    #1;
    chk("areset_held_valid", 32'(bus.output_valid), 32'd0);
    #2 reset_n = 1'b1;
    #1;
    chk("areset_first_ready", 32'(bus.input_ready), 32'b0001);
    tick();
    chk("areset_first_channel", 32'(bus.output_channel), 32'd0);
    chk("areset_first_data", 32'(bus.output_signal), 32'hA0);
    chk("areset_first_count", 32'(bus.transfer_count), 32'd1);

    // Three-channel instance: out-of-range selection and counter wrap
    bus.input_valid = 4'b0000;
    do_reset();
    bus3.mode = 1'b0; bus3.selection = 2'd3; bus3.input_valid = 3'b111;
    #1;
    chk("ch3_sel3_ready", 32'(bus3.input_ready), 32'd0);
    tick();
    chk("ch3_sel3_valid", 32'(bus3.output_valid), 32'd0);
    chk("ch3_sel3_count", 32'(bus3.transfer_count), 32'd0);
    bus3.mode = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k < 4) chk($sformatf("ch3_rr%0d_channel", k), 32'(bus3.output_channel), 32'(k % 3));
      if (k == 14) chk("ch3_count15", 32'(bus3.transfer_count), 32'd15);
      if (k == 15) chk("ch3_count_wrap", 32'(bus3.transfer_count), 32'd0);
    end
    chk("ch3_wrap_channel", 32'(bus3.output_channel), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiplexer_n_to_1_stream.md
Name: multiplexer_n_to_1_stream

Overview:
Parametrised successor to the team's 2:1 combinational multiplexer. It selects one of CHANNEL_COUNT input channels, each DATA_WIDTH bits wide, and passes it through a registered valid/ready output stage. Selection is either fixed, from the selection port, or round-robin among valid channels. It sits between multiple producers and a single consumer in datapath merge points.

Parameters:
CHANNEL_COUNT, 4, number of input channels (2..16)
DATA_WIDTH, 8, bits per channel
SELECTION_WIDTH, $clog2(CHANNEL_COUNT), width of channel index ports
COUNT_WIDTH, 16, width of the accepted-transfer counter

Ports:
clock  input  1  sole clock; all state updates on its rising edge
reset_n  input  1  asynchronous, active-low reset
input_signal  input  CHANNEL_COUNT*DATA_WIDTH  packed channel data; channel i at [i*DATA_WIDTH +: DATA_WIDTH]
input_valid  input  CHANNEL_COUNT  per-channel valid
input_ready  output  CHANNEL_COUNT  per-channel ready (one-hot or zero)
selection  input  SELECTION_WIDTH  channel index used in fixed mode
mode  input  1  0 = fixed selection, 1 = round-robin
output_signal  output  DATA_WIDTH  registered selected data
output_valid  output  1  output_signal holds an unconsumed word
output_ready  input  1  consumer accepts the word when output_valid && output_ready
output_channel  output  SELECTION_WIDTH  index of the channel that sourced output_signal
transfer_count  output  COUNT_WIDTH  number of accepted input transfers, wraps modulo 2^COUNT_WIDTH

Behaviour:
- Clock and reset are fixed: one clock; the asynchronous active-low reset clears all state immediately, independent of clock.
- Reset values: output_valid=0, output_signal=0, output_channel=0, transfer_count=0, round-robin last_grant=CHANNEL_COUNT-1, so channel 0 has first priority.
- load_enable = !output_valid || output_ready. This gives full throughput of one word per cycle with no bubble under continuous ready.
- Grant, fixed mode: grant channel = selection when input_valid[selection]=1. No grant if that channel is invalid or selection >= CHANNEL_COUNT. Other channels are never granted.
- Grant, round-robin mode: the first valid channel scanning last_grant+1, last_grant+2, … with wrap-around modulo CHANNEL_COUNT. last_grant itself is checked last. No grant if no channel is valid.
- input_ready[g] = load_enable for the granted channel g; all other bits are 0. input_ready is combinational from input_valid, mode, selection and output state.
- Transfer: input_valid[g] && input_ready[g]. At the next edge: output_signal <= data of g, output_channel <= g, output_valid <= 1, transfer_count <= transfer_count+1 (wraps), and last_grant <= g in both modes.
- If load_enable=1 and there is no grant: output_valid <= 0; output_signal and output_channel hold their values.
- If load_enable=0: all output registers hold; output_signal is stable while output_valid && !output_ready.
- Latency: one cycle from the input transfer to output_valid.
- The mode and selection inputs take effect in the same cycle. Changing them while output_valid=1 does not alter the held word. last_grant is retained across mode changes.
- Simultaneous consume and load in one cycle: the new word replaces the old one and output_valid stays 1.
- Reset asserted mid-transfer: the word is dropped, outputs return to reset values, and input_ready is 0 while reset_n=0.
- No combinational path from output_ready to output_signal.

Decomposition:
- Package multiplexer_pkg: mode constants MODE_FIXED=1'b0, MODE_ROUND_ROBIN=1'b1; default parameter values.
- Sub-module round_robin_arbiter (parameter CHANNEL_COUNT): inputs are the request vector and last_grant; outputs are the grant index and grant_valid. It is purely combinational, and last_grant stays in the parent.

Test Plan:
- Reset and idle: hold reset_n=0 for 3 cycles, then release with all input_valid=0 → output_valid=0, output_signal=0, output_channel=0, transfer_count=0, input_ready=4'b0000.
- Fixed mode: mode=0, selection=2, input_valid=4'b1111, channel data 8'hA0..8'hA3, output_ready=1 → input_ready=4'b0100; after 1 cycle output_signal=8'hA2, output_channel=2. After 10 cycles transfer_count=10.
- Round-robin fairness: mode=1, all four channels valid, output_ready=1 → output_channel sequence 0,1,2,3,0,1. Drop input_valid[1] → sequence skips 1 (…,3,0,2,3,0).
- Backpressure: one word held with output_ready=0 for 5 cycles → output_signal, output_channel and output_valid are stable and input_ready=0. Raise output_ready → the next word appears the following cycle with no bubble.
- Boundaries: in fixed mode, selection=3 with input_valid[3]=0, or CHANNEL_COUNT=3 with selection=3 → no transfer. Preload transfer_count to 16'hFFFF, then one transfer → 16'h0000.
- Asynchronous reset mid-stream: assert reset_n=0 between clock edges while output_valid=1 → outputs clear immediately. The first grant after release goes to channel 0.
